// File: rtl/vc_arbiter_ctrl.sv
// Routes words from two virtual-channel source FIFOs to two destination FIFOs.
// Arbitration is weighted round-robin; defining ARB_STRICT_PRIO_EN switches it to strict VC0 priority.
module vc_arbiter_ctrl #(
    parameter int unsigned DATA_SIZE  = 6,
    parameter int unsigned DEST_BIT   = 4,
    parameter int unsigned VC0_WEIGHT = 3,
    parameter int unsigned AF_DEFAULT = 3,
    parameter int unsigned AE_DEFAULT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [1:0]           umbral_af_in,
    input  logic [1:0]           umbral_ae_in,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic [DATA_SIZE-1:0] vc1_data,
    input  logic                 pause_d0,
    input  logic                 pause_d1,
    input  logic                 error_vc0,
    input  logic                 error_vc1,
    input  logic                 error_d0,
    input  logic                 error_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [1:0]           afD_o,
    output logic [1:0]           aeD_o,
    output logic [2:0]           state,
    output logic                 idle_out,
    output logic                 error_out
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_wcnt;
    logic [CNT_W-1:0]      w_wcnt_nxt;
    logic                  r_pend_valid;
    logic                  r_pend_dest;
    logic [DATA_SIZE-1:0]  r_data_d0;
    logic [DATA_SIZE-1:0]  r_data_d1;
    logic [1:0]            r_af;
    logic [1:0]            r_ae;

    logic                  w_any_err;
    logic                  w_arb_en;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic [DATA_SIZE-1:0]  w_word;
    logic                  w_dest;

    assign w_any_err = error_vc0 | error_vc1 | error_d0 | error_d1;
    // Errors and configuration requests outrank traffic, so they suppress new grants.
    assign w_arb_en  = (r_state == S_ACTIVE) && !reset && !w_any_err && !init;
    assign w_elig0   = !vc0_empty && !(vc0_data[DEST_BIT] ? pause_d1 : pause_d0);
    assign w_elig1   = !vc1_empty && !(vc1_data[DEST_BIT] ? pause_d1 : pause_d0);
    assign w_word    = w_gnt1 ? vc1_data : vc0_data;
    assign w_dest    = w_word[DEST_BIT];

    // Grant selection and weight counter update.
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_wcnt_nxt = r_wcnt;
`ifdef ARB_STRICT_PRIO_EN
        w_wcnt_nxt = '0;
        if (w_arb_en) begin
            if (w_elig0) begin
                w_gnt0 = 1'b1;
            end else if (w_elig1) begin
                w_gnt1 = 1'b1;
            end
        end
`else
        if (w_arb_en) begin
            if (w_elig0 && w_elig1) begin
                if (r_wcnt < CNT_W'(VC0_WEIGHT)) begin
                    w_gnt0     = 1'b1;
                    w_wcnt_nxt = r_wcnt + CNT_W'(1);
                end else begin
                    w_gnt1     = 1'b1;
                    w_wcnt_nxt = '0;
                end
            end else if (w_elig0) begin
                w_gnt0 = 1'b1;
            end else if (w_elig1) begin
                w_gnt1     = 1'b1;
                w_wcnt_nxt = '0;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: error > init > traffic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET: w_state_nxt = S_INIT;
            S_INIT: begin
                if (w_any_err)  w_state_nxt = S_ERROR;
                else if (!init) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_any_err)                     w_state_nxt = S_ERROR;
                else if (init)                     w_state_nxt = S_INIT;
                else if (!vc0_empty || !vc1_empty) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_any_err)                    w_state_nxt = S_ERROR;
                else if (init)                    w_state_nxt = S_INIT;
                else if (vc0_empty && vc1_empty)  w_state_nxt = S_IDLE;
            end
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_ERROR;
        endcase
    end

    // Output decode; an in-flight push is dropped if reset or an error shows up in its cycle.
    always_comb begin
        pop_vc0   = 1'b0;
        pop_vc1   = 1'b0;
        push_d0   = 1'b0;
        push_d1   = 1'b0;
        idle_out  = 1'b0;
        error_out = 1'b0;
        pop_vc0   = w_gnt0;
        pop_vc1   = w_gnt1;
        push_d0   = r_pend_valid && !r_pend_dest && !reset && !w_any_err;
        push_d1   = r_pend_valid &&  r_pend_dest && !reset && !w_any_err;
        idle_out  = (r_state == S_IDLE);
        error_out = (r_state == S_ERROR);
    end

    // Pending word capture, destination data holding registers and thresholds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_dest  <= 1'b0;
            r_data_d0    <= '0;
            r_data_d1    <= '0;
            r_wcnt       <= '0;
            r_af         <= 2'(AF_DEFAULT);
            r_ae         <= 2'(AE_DEFAULT);
        end else begin
            r_pend_valid <= w_gnt0 | w_gnt1;
            r_wcnt       <= w_wcnt_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_pend_dest <= w_dest;
                if (w_dest) r_data_d1 <= w_word;
                else        r_data_d0 <= w_word;
            end
            if (r_state == S_INIT) begin
                r_af <= umbral_af_in;
                r_ae <= umbral_ae_in;
            end
        end
    end

    assign data_d0 = r_data_d0;
    assign data_d1 = r_data_d1;
    assign afD_o   = r_af;
    assign aeD_o   = r_ae;
    assign state   = r_state;

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// Bench for vc_arbiter_ctrl: source FIFOs modelled as queues, outputs checked each cycle
// against a transaction-level reference model of the arbiter.
module tb_vc_arbiter_ctrl;

    localparam int unsigned DW = 6;
    localparam int unsigned DB = 4;
    localparam int unsigned W0 = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init = 1'b0;
    logic [1:0]    umbral_af_in = 2'd0;
    logic [1:0]    umbral_ae_in = 2'd0;
    logic          vc0_empty = 1'b1;
    logic          vc1_empty = 1'b1;
    logic [DW-1:0] vc0_data = '0;
    logic [DW-1:0] vc1_data = '0;
    logic          pause_d0 = 1'b0;
    logic          pause_d1 = 1'b0;
    logic          error_vc0 = 1'b0;
    logic          error_vc1 = 1'b0;
    logic          error_d0 = 1'b0;
    logic          error_d1 = 1'b0;
    logic          pop_vc0, pop_vc1, push_d0, push_d1, idle_out, error_out;
    logic [DW-1:0] data_d0, data_d1;
    logic [1:0]    afD_o, aeD_o;
    logic [2:0]    state;

    vc_arbiter_ctrl #(
        .DATA_SIZE(DW), .DEST_BIT(DB), .VC0_WEIGHT(W0), .AF_DEFAULT(3), .AE_DEFAULT(1)
    ) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_af_in(umbral_af_in), .umbral_ae_in(umbral_ae_in),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .pause_d0(pause_d0), .pause_d1(pause_d1),
        .error_vc0(error_vc0), .error_vc1(error_vc1),
        .error_d0(error_d0), .error_d1(error_d1),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_d0(push_d0), .push_d1(push_d1),
        .data_d0(data_d0), .data_d1(data_d1),
        .afD_o(afD_o), .aeD_o(aeD_o),
        .state(state), .idle_out(idle_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    // Reference model state (spec encoding: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR).
    int            m_state = 0;
    int            m_cnt   = 0;
    bit            m_pv    = 1'b0;
    bit            m_pdest = 1'b0;
    logic [DW-1:0] m_d0    = '0;
    logic [DW-1:0] m_d1    = '0;
    logic [1:0]    m_af    = 2'd3;
    logic [1:0]    m_ae    = 2'd1;
    bit            e_pop0, e_pop1, e_push0, e_push1, e_both;

    wire [24:0] obs = {pop_vc0, pop_vc1, push_d0, push_d1, state, idle_out, error_out,
                       afD_o, aeD_o, data_d0, data_d1};

    function automatic logic [24:0] exp_vec();
        return {e_pop0, e_pop1, e_push0, e_push1, 3'(m_state), m_state == 2, m_state == 4,
                m_af, m_ae, m_d0, m_d1};
    endfunction

    function automatic logic [DW-1:0] mk_word(bit d);
        logic [DW-1:0] w;
        w     = DW'($urandom);
        w[DB] = d;
        return w;
    endfunction

    task automatic drive_src();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = (q0.size() != 0) ? q0[0] : DW'($urandom);
        vc1_data  = (q1.size() != 0) ? q1[0] : DW'($urandom);
    endtask

    task automatic model_eval();
        bit err, arb, el0, el1;
        err    = error_vc0 | error_vc1 | error_d0 | error_d1;
        arb    = (m_state == 3) && !reset && !err && !init;
        el0    = (q0.size() != 0) && !((q0.size() != 0 && q0[0][DB]) ? pause_d1 : pause_d0);
        el1    = (q1.size() != 0) && !((q1.size() != 0 && q1[0][DB]) ? pause_d1 : pause_d0);
        e_pop0 = 1'b0;
        e_pop1 = 1'b0;
        e_both = arb && el0 && el1;
        if (arb) begin
`ifdef ARB_STRICT_PRIO_EN
            e_pop0 = el0;
            e_pop1 = !el0 && el1;
`else
            if (el0 && el1) begin
                if (m_cnt < int'(W0)) e_pop0 = 1'b1;
                else                  e_pop1 = 1'b1;
            end else begin
                e_pop0 = el0;
                e_pop1 = el1;
            end
`endif
        end
        e_push0 = m_pv && !m_pdest && !reset && !err;
        e_push1 = m_pv &&  m_pdest && !reset && !err;
    endtask

    task automatic model_adv();
        bit err;
        int nxt;
        logic [DW-1:0] w;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_pv = 1'b0; m_pdest = 1'b0;
            m_d0 = '0; m_d1 = '0; m_af = 2'd3; m_ae = 2'd1;
            return;
        end
        err = error_vc0 | error_vc1 | error_d0 | error_d1;
        case (m_state)
            0: nxt = 1;
            1: nxt = err ? 4 : (init ? 1 : 2);
            2: nxt = err ? 4 : init ? 1 : (q0.size() != 0 || q1.size() != 0) ? 3 : 2;
            3: nxt = err ? 4 : init ? 1 : (q0.size() == 0 && q1.size() == 0) ? 2 : 3;
            default: nxt = 4;
        endcase
        if (m_state == 1) begin
            m_af = umbral_af_in;
            m_ae = umbral_ae_in;
        end
        m_pv = e_pop0 | e_pop1;
        if (e_pop0 || e_pop1) begin
            w       = e_pop0 ? q0.pop_front() : q1.pop_front();
            m_pdest = w[DB];
            if (w[DB]) m_d1 = w;
            else       m_d0 = w;
        end
`ifndef ARB_STRICT_PRIO_EN
        if (e_pop1)                m_cnt = 0;
        else if (e_pop0 && e_both) m_cnt = m_cnt + 1;
`endif
        m_state = nxt;
    endtask

    task automatic prep();
        drive_src();
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic do_reset_init(input logic [1:0] af, input logic [1:0] ae);
        reset = 1'b1; init = 1'b0;
        error_vc0 = 0; error_vc1 = 0; error_d0 = 0; error_d1 = 0;
        pause_d0 = 0; pause_d1 = 0;
        q0.delete(); q1.delete();
        prep(); tick();
        reset = 1'b0; umbral_af_in = af; umbral_ae_in = ae;
        prep(); tick();
        prep(); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        prep(); tick();
        prep();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_vec: got %h want %h", obs, exp_vec());
        end
        n_cmp++;
        if ({state, afD_o, aeD_o, pop_vc0, pop_vc1, push_d0, push_d1} !== {3'd0, 2'd3, 2'd1, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_const: got st=%0d af=%0d ae=%0d", state, afD_o, aeD_o);
        end
        tick();
    endtask

    task automatic test_init();
        logic [2:0] exp_st[4];
        exp_st = '{3'd0, 3'd1, 3'd1, 3'd2};
        reset = 1'b1; init = 1'b0;
        prep(); tick();
        reset = 1'b0; umbral_af_in = 2'd2; umbral_ae_in = 2'd0;
        for (int i = 0; i < 4; i++) begin
            init = (i < 2);
            prep();
            n_cmp++;
            if (obs !== exp_vec() || state !== exp_st[i]) begin
                n_fail++;
                $display("FAIL init_seq[%0d]: got %h st=%0d want %h st=%0d", i, obs, state, exp_vec(), exp_st[i]);
            end
            tick();
        end
        prep();
        n_cmp++;
        if ({afD_o, aeD_o, idle_out} !== {2'd2, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL init_thresh: got af=%0d ae=%0d idle=%b want 2 0 1", afD_o, aeD_o, idle_out);
        end
    endtask

    task automatic test_wrr_order();
        int exp_ord[10];
        int ord[$];
`ifdef ARB_STRICT_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
`else
        exp_ord = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 1};
`endif
        do_reset_init(2'd3, 2'd1);
        for (int i = 0; i < 5; i++) begin
            q0.push_back(mk_word(1'b0));
            q1.push_back(mk_word(1'b0));
        end
        for (int c = 0; c < 16; c++) begin
            prep();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrr_cyc[%0d]: got %h want %h", c, obs, exp_vec());
            end
            if (pop_vc0 === 1'b1) ord.push_back(0);
            if (pop_vc1 === 1'b1) ord.push_back(1);
            tick();
        end
        n_cmp++;
        if (ord.size() != 10) begin
            n_fail++;
            $display("FAIL wrr_count: got %0d pops want 10", ord.size());
        end
        for (int i = 0; i < 10 && i < ord.size(); i++) begin
            n_cmp++;
            if (ord[i] != exp_ord[i]) begin
                n_fail++;
                $display("FAIL wrr_order[%0d]: got vc%0d want vc%0d", i, ord[i], exp_ord[i]);
            end
        end
    endtask

    task automatic test_no_hol();
        do_reset_init(2'd3, 2'd1);
        q0.push_back(mk_word(1'b1));
        q0.push_back(mk_word(1'b0));
        for (int i = 0; i < 8; i++) q1.push_back(mk_word(1'b0));
        pause_d1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            prep();
            n_cmp++;
            if (obs !== exp_vec() || pop_vc0 !== 1'b0 || (c > 0 && pop_vc1 !== 1'b1)) begin
                n_fail++;
                $display("FAIL hol_blocked[%0d]: got %h want %h", c, obs, exp_vec());
            end
            tick();
        end
        pause_d1 = 1'b0;
        prep();
        n_cmp++;
        if (obs !== exp_vec() || pop_vc0 !== 1'b1) begin
            n_fail++;
            $display("FAIL hol_release: got %h pop_vc0=%b want %h pop_vc0=1", obs, pop_vc0, exp_vec());
        end
        tick();
        for (int c = 0; c < 8; c++) begin
            prep();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL hol_tail[%0d]: got %h want %h", c, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_drain();
        bit done;
        do_reset_init(2'd2, 2'd1);
        for (int i = 0; i < 3; i++) q0.push_back(mk_word(i[0]));
        for (int i = 0; i < 2; i++) q1.push_back(mk_word(1'b1));
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            prep();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_cyc[%0d]: got %h want %h", c, obs, exp_vec());
            end
            tick();
            done = (q0.size() == 0 && q1.size() == 0);
        end
        prep();
        n_cmp++;
        if (!done || (push_d0 | push_d1) !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL drain_last: got push=%b%b st=%0d want one push st=3", push_d0, push_d1, state);
        end
        tick();
        prep();
        n_cmp++;
        if (state !== 3'd2 || idle_out !== 1'b1 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL drain_idle: got st=%0d idle=%b want st=2 idle=1", state, idle_out);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset_init(2'($urandom), 2'($urandom));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 6) q0.push_back(mk_word(1'($urandom)));
            if ($urandom_range(0, 2) == 0 && q1.size() < 6) q1.push_back(mk_word(1'($urandom)));
            pause_d0     = ($urandom_range(0, 3) == 0);
            pause_d1     = ($urandom_range(0, 3) == 0);
            init         = ($urandom_range(0, 63) == 0);
            umbral_af_in = 2'($urandom);
            umbral_ae_in = 2'($urandom);
            prep();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_cyc[%0d]: got %h want %h", c, obs, exp_vec());
            end
            tick();
        end
        pause_d0 = 1'b0; pause_d1 = 1'b0; init = 1'b0;
        for (int c = 0; c < 30; c++) begin
            prep();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_drain[%0d]: got %h want %h", c, obs, exp_vec());
            end
            tick();
        end
        prep();
        n_cmp++;
        if (idle_out !== 1'b1 || q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL rand_final_idle: got idle=%b q0=%0d q1=%0d want idle=1 empty", idle_out, q0.size(), q1.size());
        end
    endtask

    task automatic test_error();
        bit found;
        do_reset_init(2'd2, 2'd2);
        for (int i = 0; i < 8; i++) q0.push_back(mk_word(1'b0));
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            prep();
            if (m_state == 3 && m_pv) begin
                found = 1'b1;
            end else begin
                tick();
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL err_setup: got no pending word want one within 20 cycles");
        end
        error_d0 = 1'b1;
        prep();
        n_cmp++;
        if (obs !== exp_vec() || push_d0 !== 1'b0 || pop_vc0 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_discard: got %h want %h", obs, exp_vec());
        end
        tick();
        error_d0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            prep();
            n_cmp++;
            if (obs !== exp_vec() || state !== 3'd4 || error_out !== 1'b1 || (pop_vc0 | push_d0) !== 1'b0) begin
                n_fail++;
                $display("FAIL err_sticky[%0d]: got %h st=%0d want %h st=4", c, obs, state, exp_vec());
            end
            tick();
        end
        reset = 1'b1;
        prep(); tick();
        prep();
        n_cmp++;
        if (state !== 3'd0 || error_out !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL err_reset: got st=%0d err=%b want st=0 err=0", state, error_out);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset_init(2'd2, 2'd3);
        for (int i = 0; i < 4; i++) q0.push_back(mk_word(1'b1));
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            prep();
            found = e_pop0 | e_pop1;
            tick();
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL rmid_setup: got no grant want one within 20 cycles");
        end
        reset = 1'b1;
        prep();
        n_cmp++;
        if (obs !== exp_vec() || push_d0 !== 1'b0 || push_d1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_nopush: got %h want %h", obs, exp_vec());
        end
        tick();
        prep();
        n_cmp++;
        if (obs !== {4'b0, 3'd0, 2'b00, 2'd3, 2'd1, 12'd0}) begin
            n_fail++;
            $display("FAIL rmid_outputs: got %h want %h", obs, {4'b0, 3'd0, 2'b00, 2'd3, 2'd1, 12'd0});
        end
        reset = 1'b0;
        q0.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200us");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_wrr_order();
        test_no_hol();
        test_drain();
        test_random();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
